// File: rtl/uart_rx_gen2.sv
// Oversampled UART receiver: 3-sample majority vote per bit, 1/2 stop bits and parity, with a valid/ready holding register.
// P_DATA is valid 1 cycle after the last stop bit ends; a full register drops new frames (OVERRUN); UART_RX_BREAK_DET_EN adds break detection.
module uart_rx_gen2 #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESCALE_W  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  DATA_VALID,
  input  logic                  DATA_READY,
  output logic                  OVERRUN,
  output logic                  BRK_DET
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
`ifdef UART_RX_BREAK_DET_EN
    , BRK_WAIT
`endif
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  state_t                 state_q;
  logic [PRESCALE_W-1:0]  edge_cnt_q, edge_cnt_d, p_clamp, mid;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [2:0]             smp_q;
  logic                   bit_end, bit_val;
  logic                   stop_cnt_q, par_err_q, stp_err_q, stp_err_d;
  logic [DATA_WIDTH-1:0]  p_data_q;
  logic                   par_out_q, stp_out_q, dv_q, ovr_q;
`ifdef UART_RX_BREAK_DET_EN
  logic                   zero_q, brk_q;
`endif

  always_ff @(posedge CLK) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN};
  end
  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    p_clamp    = (prescale < PRESCALE_W'(4)) ? PRESCALE_W'(4) : prescale;
    mid        = p_clamp >> 1;
    bit_end    = (edge_cnt_q == p_clamp);
    bit_val    = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    edge_cnt_d = (state_q == IDLE || bit_end) ? PRESCALE_W'(1) : edge_cnt_q + PRESCALE_W'(1);
    bit_cnt_d  = bit_cnt_q + 4'd1;
    shift_d    = {bit_val, shift_q[DATA_WIDTH-1:1]};
    stp_err_d  = stp_err_q | ~bit_val;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= IDLE;
      edge_cnt_q <= PRESCALE_W'(1);
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      smp_q      <= '1;
      stop_cnt_q <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      p_data_q   <= '0;
      par_out_q  <= 1'b0;
      stp_out_q  <= 1'b0;
      dv_q       <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      zero_q     <= 1'b1;
      brk_q      <= 1'b0;
`endif
    end else begin
      ovr_q      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_q      <= 1'b0;
`endif
      edge_cnt_q <= edge_cnt_d;
      if (dv_q && DATA_READY) dv_q <= 1'b0;
      if (edge_cnt_q == mid - PRESCALE_W'(1)) smp_q[0] <= rxs;
      if (edge_cnt_q == mid)                  smp_q[1] <= rxs;
      if (edge_cnt_q == mid + PRESCALE_W'(1)) smp_q[2] <= rxs;

      case (state_q)
        IDLE: if (!rxs) state_q <= START;
        START: if (bit_end) begin
          if (bit_val) begin
            state_q <= IDLE;
          end else begin
            state_q    <= DATA;
            bit_cnt_q  <= 4'd0;
            stop_cnt_q <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            zero_q     <= 1'b1;
`endif
          end
        end
        DATA: if (bit_end) begin
          shift_q   <= shift_d;
          bit_cnt_q <= bit_cnt_d;
`ifdef UART_RX_BREAK_DET_EN
          zero_q    <= zero_q & ~bit_val;
`endif
          if (bit_cnt_d == 4'(DATA_WIDTH)) state_q <= PAR_EN ? PARITY : STOP;
        end
        PARITY: if (bit_end) begin
          par_err_q <= ((^shift_q) ^ PAR_TYP) != bit_val;
`ifdef UART_RX_BREAK_DET_EN
          zero_q    <= zero_q & ~bit_val;
`endif
          state_q   <= STOP;
        end
        STOP: if (bit_end) begin
          stp_err_q <= stp_err_d;
`ifdef UART_RX_BREAK_DET_EN
          if (!stop_cnt_q && zero_q && !bit_val) begin
            brk_q   <= 1'b1;
            state_q <= BRK_WAIT;
          end else
`endif
          if (STOP2 && !stop_cnt_q) begin
            stop_cnt_q <= 1'b1;
          end else begin
            // A frame may load in the same cycle the held one is accepted.
            state_q <= IDLE;
            if (!dv_q || DATA_READY) begin
              p_data_q  <= shift_q;
              par_out_q <= par_err_q;
              stp_out_q <= stp_err_d;
              dv_q      <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        BRK_WAIT: if (rxs) state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign P_DATA     = p_data_q;
  assign PAR_ERR    = par_out_q;
  assign STP_ERR    = stp_out_q;
  assign DATA_VALID = dv_q;
  assign OVERRUN    = ovr_q;
`ifdef UART_RX_BREAK_DET_EN
  assign BRK_DET    = brk_q;
`else
  assign BRK_DET    = 1'b0;
`endif

endmodule
